// File: rtl/execute.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply/divide unit
// with HI/LO registers, and the EX/MEM pipeline register.
module execute (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IdExReadData1,
    input  logic [31:0] IdExReadData2,
    input  logic [31:0] IdExImmediate,
    input  logic [4:0]  IdExShamt,
    input  logic [3:0]  IdExAluCtrl,
    input  logic [1:0]  IdExHiLoRead,
    input  logic        IdExAluSrc,
    input  logic [4:0]  IdExRt,
    input  logic [4:0]  IdExRd,
    input  logic        IdExRegDst,
    input  logic        IdExMemRead,
    input  logic        IdExMemWrite,
    input  logic        IdExRegWrite,
    input  logic        IdExMemToReg,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] MemWbWriteData,
    output logic [31:0] ExMemAluOutput,
    output logic [31:0] ExMemReadData2,
    output logic [4:0]  WriteBackDest,
    output logic        writeMemoryEnable,
    output logic        readMemoryEnable,
    output logic        ExMemwriteRegEnable,
    output logic        ExMemwritebackRegCtrl,
    output logic        ExStall
);

    typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mduState_e;

    mduState_e   state, stateNext;
    logic [4:0]  count;
    logic [31:0] opA, fwdB, opB, aluResult, exResult;
    logic [31:0] accReg, quoReg, divisorReg, dividendReg, hiReg, loReg;
    logic [31:0] magA, magB, stepAcc, stepQuo, finalHi, finalLo;
    logic [32:0] mulSum, remShift;
    logic [63:0] product;
    logic        isMduOp, isSignedOp, isDiv, negResult, negRem, divByZero;

    always_comb begin
        opA = IdExReadData1;
        case (ForwardA)
            2'b01:   opA = MemWbWriteData;
            2'b10:   opA = ExMemAluOutput;
            default: opA = IdExReadData1;
        endcase
        fwdB = IdExReadData2;
        case (ForwardB)
            2'b01:   fwdB = MemWbWriteData;
            2'b10:   fwdB = ExMemAluOutput;
            default: fwdB = IdExReadData2;
        endcase
        opB = IdExAluSrc ? IdExImmediate : fwdB;
    end

    always_comb begin
        aluResult = 32'h0;
        case (IdExAluCtrl)
            4'd0:    aluResult = opA & opB;
            4'd1:    aluResult = opA | opB;
            4'd2:    aluResult = opA + opB;
            4'd3:    aluResult = opA ^ opB;
            4'd4:    aluResult = ~(opA | opB);
            4'd5:    aluResult = opB << IdExShamt;
            4'd6:    aluResult = opB >> IdExShamt;
            4'd7:    aluResult = $signed(opB) >>> IdExShamt;
            4'd8:    aluResult = opA - opB;
            4'd9:    aluResult = {31'b0, $signed(opA) < $signed(opB)};
            4'd10:   aluResult = {31'b0, opA < opB};
            4'd11:   aluResult = {opB[15:0], 16'h0};
            default: aluResult = 32'h0;
        endcase
        exResult = aluResult;
        case (IdExHiLoRead)
            2'b01:   exResult = hiReg;
            2'b10:   exResult = loReg;
            default: exResult = aluResult;
        endcase
    end

    assign isMduOp    = (IdExAluCtrl[3:2] == 2'b11);
    assign isSignedOp = ~IdExAluCtrl[0];
    assign magA       = (isSignedOp && opA[31]) ? -opA : opA;
    assign magB       = (isSignedOp && opB[31]) ? -opB : opB;

    always_ff @(posedge clk) begin
        if (reset) state <= MDU_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            MDU_IDLE: if (isMduOp) stateNext = MDU_BUSY;
            MDU_BUSY: if (count == 5'd31) stateNext = MDU_DONE;
            MDU_DONE: stateNext = MDU_IDLE;
            default:  stateNext = MDU_IDLE;
        endcase
    end

    assign ExStall = !reset && (((state == MDU_IDLE) && isMduOp) || (state == MDU_BUSY));

    // Multiply and divide share {accReg, quoReg}: quoReg starts as the left magnitude and
    // shifts out LSB-first for multiply or MSB-first for division.
    always_comb begin
        mulSum   = {1'b0, accReg} + (quoReg[0] ? {1'b0, divisorReg} : 33'd0);
        remShift = {accReg, quoReg[31]};
        if (isDiv) begin
            if (remShift >= {1'b0, divisorReg}) begin
                stepAcc = remShift[31:0] - divisorReg;
                stepQuo = {quoReg[30:0], 1'b1};
            end else begin
                stepAcc = remShift[31:0];
                stepQuo = {quoReg[30:0], 1'b0};
            end
        end else begin
            stepAcc = mulSum[32:1];
            stepQuo = {mulSum[0], quoReg[31:1]};
        end
    end

    always_comb begin
        product = {stepAcc, stepQuo};
        if (negResult) product = -product;
        finalHi = product[63:32];
        finalLo = product[31:0];
        if (isDiv) begin
            if (divByZero) begin
                finalHi = dividendReg;
                finalLo = 32'hFFFF_FFFF;
            end else begin
                finalHi = negRem    ? -stepAcc : stepAcc;
                finalLo = negResult ? -stepQuo : stepQuo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= 5'd0;
            accReg      <= 32'h0;
            quoReg      <= 32'h0;
            divisorReg  <= 32'h0;
            dividendReg <= 32'h0;
            isDiv       <= 1'b0;
            negResult   <= 1'b0;
            negRem      <= 1'b0;
            divByZero   <= 1'b0;
            hiReg       <= 32'h0;
            loReg       <= 32'h0;
        end else if (state == MDU_IDLE && isMduOp) begin
            count       <= 5'd0;
            accReg      <= 32'h0;
            quoReg      <= magA;
            divisorReg  <= magB;
            dividendReg <= opA;
            isDiv       <= IdExAluCtrl[1];
            negResult   <= isSignedOp && (opA[31] ^ opB[31]);
            negRem      <= isSignedOp && opA[31];
            divByZero   <= (opB == 32'h0);
        end else if (state == MDU_BUSY) begin
            accReg <= stepAcc;
            quoReg <= stepQuo;
            count  <= count + 5'd1;
            if (count == 5'd31) begin
                hiReg <= finalHi;
                loReg <= finalLo;
            end
        end
    end

    // The DONE cycle retires the mult/div as a bubble, same as the stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            ExMemAluOutput        <= 32'h0;
            ExMemReadData2        <= 32'h0;
            WriteBackDest         <= 5'd0;
            writeMemoryEnable     <= 1'b0;
            readMemoryEnable      <= 1'b0;
            ExMemwriteRegEnable   <= 1'b0;
            ExMemwritebackRegCtrl <= 1'b0;
        end else if (ExStall || state == MDU_DONE) begin
            writeMemoryEnable     <= 1'b0;
            readMemoryEnable      <= 1'b0;
            ExMemwriteRegEnable   <= 1'b0;
            ExMemwritebackRegCtrl <= 1'b0;
        end else begin
            ExMemAluOutput        <= exResult;
            ExMemReadData2        <= fwdB;
            WriteBackDest         <= IdExRegDst ? IdExRd : IdExRt;
            writeMemoryEnable     <= IdExMemWrite;
            readMemoryEnable      <= IdExMemRead;
            ExMemwriteRegEnable   <= IdExRegWrite;
            ExMemwritebackRegCtrl <= IdExMemToReg;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed testbench for the execute stage: scoreboard of expected EX/MEM contents
// plus bounded walks through multiply/divide stalls, reset abort and back-to-back ops.
module tb_execute;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IdExReadData1, IdExReadData2, IdExImmediate, MemWbWriteData;
    logic [4:0]  IdExShamt, IdExRt, IdExRd;
    logic [3:0]  IdExAluCtrl;
    logic [1:0]  IdExHiLoRead, ForwardA, ForwardB;
    logic        IdExAluSrc, IdExRegDst, IdExMemRead, IdExMemWrite, IdExRegWrite, IdExMemToReg;
    logic [31:0] ExMemAluOutput, ExMemReadData2;
    logic [4:0]  WriteBackDest;
    logic        writeMemoryEnable, readMemoryEnable, ExMemwriteRegEnable, ExMemwritebackRegCtrl;
    logic        ExStall;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  dest;
        logic [3:0]  ctrl;
    } expect_t;

    expect_t     sbQueue[$];
    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] modelHi, modelLo;

    always #5 clk = ~clk;

    execute dut (
        .clk(clk), .reset(reset),
        .IdExReadData1(IdExReadData1), .IdExReadData2(IdExReadData2),
        .IdExImmediate(IdExImmediate), .IdExShamt(IdExShamt),
        .IdExAluCtrl(IdExAluCtrl), .IdExHiLoRead(IdExHiLoRead),
        .IdExAluSrc(IdExAluSrc), .IdExRt(IdExRt), .IdExRd(IdExRd),
        .IdExRegDst(IdExRegDst), .IdExMemRead(IdExMemRead),
        .IdExMemWrite(IdExMemWrite), .IdExRegWrite(IdExRegWrite),
        .IdExMemToReg(IdExMemToReg), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MemWbWriteData(MemWbWriteData), .ExMemAluOutput(ExMemAluOutput),
        .ExMemReadData2(ExMemReadData2), .WriteBackDest(WriteBackDest),
        .writeMemoryEnable(writeMemoryEnable), .readMemoryEnable(readMemoryEnable),
        .ExMemwriteRegEnable(ExMemwriteRegEnable),
        .ExMemwritebackRegCtrl(ExMemwritebackRegCtrl), .ExStall(ExStall)
    );

    function automatic logic [31:0] aluModel(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return ~(a | b);
            4'd5:    return b << sh;
            4'd6:    return b >> sh;
            4'd7:    return (b >> sh) | (b[31] ? ~(ones >> sh) : 32'h0);
            4'd8:    return a - b;
            4'd9:    return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            4'd10:   return {31'b0, a < b};
            4'd11:   return {b[15:0], 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic updateModel(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (c)
            4'd12: begin sp = sa * sb; modelHi = sp[63:32]; modelLo = sp[31:0]; end
            4'd13: begin up = ua * ub; modelHi = up[63:32]; modelLo = up[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    modelHi = a;
                    modelLo = 32'hFFFF_FFFF;
                end else if (c == 4'd14) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    modelLo = sq[31:0];
                    modelHi = sr[31:0];
                end else begin
                    modelLo = a / b;
                    modelHi = a % b;
                end
            end
        endcase
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setNop();
        IdExReadData1  = 32'h0;
        IdExReadData2  = 32'h0;
        IdExImmediate  = 32'h0;
        MemWbWriteData = 32'h0;
        IdExShamt      = 5'd0;
        IdExRt         = 5'd0;
        IdExRd         = 5'd0;
        IdExAluCtrl    = 4'd0;
        IdExHiLoRead   = 2'b00;
        ForwardA       = 2'b00;
        ForwardB       = 2'b00;
        IdExAluSrc     = 1'b0;
        IdExRegDst     = 1'b0;
        IdExMemRead    = 1'b0;
        IdExMemWrite   = 1'b0;
        IdExRegWrite   = 1'b0;
        IdExMemToReg   = 1'b0;
    endtask

    // Expected destination and control bits come from what the bench itself drove.
    task automatic applyStimulus(input string tag, input logic [31:0] expAlu, input logic [31:0] expRd2);
        expect_t e;
        e.tag  = tag;
        e.alu  = expAlu;
        e.rd2  = expRd2;
        e.dest = IdExRegDst ? IdExRd : IdExRt;
        e.ctrl = {IdExMemWrite, IdExMemRead, IdExRegWrite, IdExMemToReg};
        sbQueue.push_back(e);
        @(negedge clk);
    endtask

    task automatic checkOutput();
        expect_t e;
        assertCount++;
        assert (sbQueue.size() > 0) else begin
            failCount++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkValue({e.tag, " alu"}, ExMemAluOutput, e.alu);
            checkValue({e.tag, " rd2"}, ExMemReadData2, e.rd2);
            checkValue({e.tag, " dest"}, {27'b0, WriteBackDest}, {27'b0, e.dest});
            checkValue({e.tag, " ctrl"},
                       {28'b0, writeMemoryEnable, readMemoryEnable, ExMemwriteRegEnable, ExMemwritebackRegCtrl},
                       {28'b0, e.ctrl});
        end
    endtask

    task automatic readHiLo(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        setNop();
        IdExAluCtrl  = 4'd2;
        IdExHiLoRead = sel;
        IdExRegWrite = 1'b1;
        IdExRegDst   = 1'b1;
        IdExRd       = 5'd10;
        applyStimulus(tag, exp, 32'h0);
        checkOutput();
    endtask

    task automatic runMdu(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int edges;
        int badCtrl;
        setNop();
        IdExAluCtrl   = c;
        IdExReadData1 = a;
        IdExReadData2 = b;
        IdExRegWrite  = 1'b1;
        IdExMemWrite  = 1'b1;
        updateModel(c, a, b);
        edges   = 0;
        badCtrl = 0;
        #1;
        while (ExStall === 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
            if ({writeMemoryEnable, readMemoryEnable, ExMemwriteRegEnable, ExMemwritebackRegCtrl} !== 4'b0)
                badCtrl++;
        end
        checkValue({tag, " stall length"}, edges, 33);
        checkValue({tag, " ctrl during stall"}, badCtrl, 0);
        checkValue({tag, " stall in done"}, {31'b0, ExStall}, 32'h0);
        @(negedge clk);
        checkValue({tag, " done bubble ctrl"},
                   {28'b0, writeMemoryEnable, readMemoryEnable, ExMemwriteRegEnable, ExMemwritebackRegCtrl}, 32'h0);
        setNop();
    endtask

    initial begin
        int edges;
        logic [31:0] ra, rb;

        setNop();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkValue("reset alu", ExMemAluOutput, 32'h0);
        checkValue("reset rd2", ExMemReadData2, 32'h0);
        checkValue("reset dest", {27'b0, WriteBackDest}, 32'h0);
        checkValue("reset ctrl",
                   {28'b0, writeMemoryEnable, readMemoryEnable, ExMemwriteRegEnable, ExMemwritebackRegCtrl}, 32'h0);
        checkValue("reset stall", {31'b0, ExStall}, 32'h0);
        reset = 1'b0;

        setNop();
        IdExAluCtrl = 4'd2; IdExReadData1 = 32'd2; IdExReadData2 = 32'd3;
        IdExRegWrite = 1'b1; IdExRegDst = 1'b1; IdExRd = 5'd9;
        applyStimulus("add", 32'd5, 32'd3);
        checkOutput();

        setNop();
        IdExAluCtrl = 4'd2; ForwardA = 2'b10; IdExReadData1 = 32'd99; IdExReadData2 = 32'd7;
        IdExRegWrite = 1'b1; IdExRt = 5'd4;
        applyStimulus("fwdA add", 32'd12, 32'd7);
        checkOutput();

        setNop();
        IdExAluCtrl = 4'd8; ForwardB = 2'b01; MemWbWriteData = 32'h100;
        IdExReadData1 = 32'd1; IdExReadData2 = 32'hDEAD; IdExMemWrite = 1'b1; IdExRt = 5'd6;
        applyStimulus("fwdB sub", 32'hFFFF_FF01, 32'h100);
        checkOutput();

        setNop();
        IdExAluCtrl = 4'd7; IdExAluSrc = 1'b1; IdExImmediate = 32'h8000_0000; IdExShamt = 5'd4;
        IdExReadData2 = 32'h55; IdExRt = 5'd3; IdExRegWrite = 1'b1;
        applyStimulus("sra", 32'hF800_0000, 32'h55);
        checkOutput();

        setNop();
        IdExAluCtrl = 4'd9; IdExReadData1 = 32'hFFFF_FFFF; IdExReadData2 = 32'd1;
        IdExMemRead = 1'b1; IdExMemToReg = 1'b1; IdExRegWrite = 1'b1;
        applyStimulus("slt", 32'd1, 32'd1);
        checkOutput();

        setNop();
        IdExAluCtrl = 4'd10; IdExReadData1 = 32'hFFFF_FFFF; IdExReadData2 = 32'd1; IdExRegWrite = 1'b1;
        applyStimulus("sltu", 32'd0, 32'd1);
        checkOutput();

        setNop();
        IdExAluCtrl = 4'd11; IdExAluSrc = 1'b1; IdExImmediate = 32'h0000_ABCD; IdExRegWrite = 1'b1;
        applyStimulus("lui", 32'hABCD_0000, 32'h0);
        checkOutput();

        for (int i = 0; i < 24; i++) begin
            setNop();
            IdExAluCtrl   = 4'(i % 12);
            IdExReadData1 = $urandom;
            IdExReadData2 = $urandom;
            IdExShamt     = 5'($urandom_range(0, 31));
            IdExRegWrite  = 1'($urandom_range(0, 1));
            IdExRt        = 5'($urandom_range(0, 31));
            applyStimulus($sformatf("alu op%0d", i % 12),
                          aluModel(IdExAluCtrl, IdExReadData1, IdExReadData2, IdExShamt), IdExReadData2);
            checkOutput();
        end

        readHiLo("hi after reset", 2'b01, 32'h0);

        runMdu("mult", 4'd12, 32'hFFFF_FFFF, 32'd3);
        readHiLo("mult hi", 2'b01, 32'hFFFF_FFFF);
        readHiLo("mult lo", 2'b10, 32'hFFFF_FFFD);

        runMdu("div", 4'd14, 32'hFFFF_FFF9, 32'd2);
        readHiLo("div lo", 2'b10, 32'hFFFF_FFFD);
        readHiLo("div hi", 2'b01, 32'hFFFF_FFFF);

        runMdu("divu0", 4'd15, 32'd7, 32'd0);
        readHiLo("divu0 lo", 2'b10, 32'hFFFF_FFFF);
        readHiLo("divu0 hi", 2'b01, 32'd7);

        runMdu("div ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        readHiLo("div ovf lo", 2'b10, 32'h8000_0000);
        readHiLo("div ovf hi", 2'b01, 32'h0);

        ra = $urandom; rb = $urandom;
        runMdu("multu rand", 4'd13, ra, rb);
        readHiLo("multu rand hi", 2'b01, modelHi);
        readHiLo("multu rand lo", 2'b10, modelLo);

        ra = $urandom; rb = $urandom | 32'h1;
        runMdu("div rand", 4'd14, ra, rb);
        readHiLo("div rand lo", 2'b10, modelLo);
        readHiLo("div rand hi", 2'b01, modelHi);

        // Abort a MULTU ten cycles into BUSY.
        setNop();
        IdExAluCtrl = 4'd13; IdExReadData1 = 32'hFFFF_FFFF; IdExReadData2 = 32'hFFFF_FFFF; IdExRegWrite = 1'b1;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        #1;
        checkValue("stall during reset", {31'b0, ExStall}, 32'h0);
        @(negedge clk);
        checkValue("abort alu", ExMemAluOutput, 32'h0);
        checkValue("abort rd2", ExMemReadData2, 32'h0);
        checkValue("abort dest", {27'b0, WriteBackDest}, 32'h0);
        checkValue("abort ctrl",
                   {28'b0, writeMemoryEnable, readMemoryEnable, ExMemwriteRegEnable, ExMemwritebackRegCtrl}, 32'h0);
        reset = 1'b0;
        setNop();
        #1;
        checkValue("idle after abort", {31'b0, ExStall}, 32'h0);
        @(negedge clk);
        readHiLo("abort hi", 2'b01, 32'h0);
        readHiLo("abort lo", 2'b10, 32'h0);

        // Two MULTs back to back: the second appears once the first's DONE cycle retires.
        setNop();
        IdExAluCtrl = 4'd12; IdExReadData1 = 32'd6; IdExReadData2 = 32'd7;
        edges = 0;
        #1;
        while (ExStall === 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        @(negedge clk);
        edges++;
        IdExReadData1 = 32'hFFFF_FFFB; IdExReadData2 = 32'd7;
        updateModel(4'd12, IdExReadData1, IdExReadData2);
        #1;
        checkValue("b2b second start", {31'b0, ExStall}, 32'h1);
        while (ExStall === 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        @(negedge clk);
        edges++;
        checkValue("b2b total cycles", edges, 68);
        readHiLo("b2b lo", 2'b10, 32'hFFFF_FFDD);
        readHiLo("b2b hi", 2'b01, modelHi);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
